// File: rtl/vli_encoder.sv
// Purpose: JPEG VLI encoder. Maps each zig-zag coefficient (DC predicted, AC direct) to a {size, symbol} pair.
// Latency: 2 cycles from input accept to out_valid. Throughput is one pair per cycle.
// Backpressure: valid/ready on both sides. in_ready = !s1_valid | !s2_valid | out_ready. Outputs hold while stalled.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_coef/in_is_dc : coefficient stream
//   restart                            : one-cycle pulse that clears the DC predictor
//   out_valid/out_ready/out_size/out_symbol : encoded pair stream
//   range_err                          : sticky flag, set when a value was clamped to +/-2047
module vli_encoder #(
  parameter int COEF_W = 12,
  parameter int SIZE_W = 4,
  parameter int SYM_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_is_dc,
  input  logic                     restart,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_W-1:0]        out_size,
  output logic [SYM_W-1:0]         out_symbol,
  output logic                     range_err
);

  localparam int MAXV = (1 << SYM_W) - 1;
  localparam logic signed [COEF_W:0] VMAX = (COEF_W+1)'(MAXV);
  localparam logic signed [COEF_W:0] VMIN = -VMAX;

  // Pipeline and predictor state
  logic signed [COEF_W-1:0] pred_q, pred_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [SYM_W:0]    s1_v_q, s1_v_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [SIZE_W-1:0]        size_q, size_d;
  logic [SYM_W-1:0]         sym_q, sym_d;
  logic                     err_q, err_d;

  logic                     s2_adv, s1_adv, acc;
  logic signed [COEF_W:0]   coef_ext, pred_eff, v_raw;
  logic signed [SYM_W:0]    v_clamp;
  logic                     clamped;
  logic signed [SYM_W:0]    mag_full;
  logic [SYM_W-1:0]         mag, mask;
  logic [SIZE_W-1:0]        enc_size;
  logic [SYM_W-1:0]         enc_sym;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign acc      = in_valid && in_ready;

  // Select and clamp the value to encode. A restart on the same cycle
  // makes this DC use a zero predictor.
  always_comb begin
    coef_ext = {in_coef[COEF_W-1], in_coef};
    pred_eff = restart ? '0 : {pred_q[COEF_W-1], pred_q};
    v_raw    = in_is_dc ? (coef_ext - pred_eff) : coef_ext;
    clamped  = 1'b0;
    v_clamp  = v_raw[SYM_W:0];
    if (v_raw > VMAX) begin
      v_clamp = VMAX[SYM_W:0];
      clamped = 1'b1;
    end else if (v_raw < VMIN) begin
      v_clamp = VMIN[SYM_W:0];
      clamped = 1'b1;
    end
  end

  // Category is the bit length of |v|. Negative values send the ones'
  // complement of |v| in the low size bits.
  always_comb begin
    mag_full = s1_v_q[SYM_W] ? -s1_v_q : s1_v_q;
    mag      = mag_full[SYM_W-1:0];
    enc_size = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (mag[i]) enc_size = SIZE_W'(i + 1);
    end
    mask    = ~({SYM_W{1'b1}} << enc_size);
    enc_sym = s1_v_q[SYM_W] ? (~mag & mask) : mag;
  end

  always_comb begin
    pred_d     = pred_q;
    s1_valid_d = s1_valid_q;
    s1_v_d     = s1_v_q;
    s2_valid_d = s2_valid_q;
    size_d     = size_q;
    sym_d      = sym_q;
    err_d      = err_q;

    // The predictor tracks the raw coefficient, never the clamped difference.
    if (acc && in_is_dc) pred_d = in_coef;
    else if (restart)    pred_d = '0;

    if (acc && clamped) err_d = 1'b1;

    if (s1_adv) begin
      s1_valid_d = acc;
      if (acc) s1_v_d = v_clamp;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        size_d = enc_size;
        sym_d  = enc_sym;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_v_q     <= '0;
      s2_valid_q <= 1'b0;
      size_q     <= '0;
      sym_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pred_q     <= pred_d;
      s1_valid_q <= s1_valid_d;
      s1_v_q     <= s1_v_d;
      s2_valid_q <= s2_valid_d;
      size_q     <= size_d;
      sym_q      <= sym_d;
      err_q      <= err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_size   = size_q;
  assign out_symbol = sym_q;
  assign range_err  = err_q;

endmodule
